// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the instruction fetch path.
//   fetch_state_e     : fetch FSM state encoding (IDLE, REQ, HOLD)
//   PC_STEP_DEFAULT   : byte distance between sequential instructions
//   RESET_PC_DEFAULT  : program counter value after reset
//   sext_imm16_x4()   : sign-extends a 16-bit word offset into a 32-bit
//                       byte offset (offset * 4)
// ----------------------------------------------------------------------------
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

  localparam logic [31:0] PC_STEP_DEFAULT  = 32'd4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Branch offsets count instructions, not bytes, so the field is shifted
  // left by two after sign extension.
  function automatic logic [31:0] sext_imm16_x4(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// ----------------------------------------------------------------------------
// fetch_unit_if
// Bundles the instruction-memory bus, the decoder hand-off and the decoder's
// control feedback used by the fetch unit.
//   imem_req/imem_addr        : fetch request and byte address to memory
//   imem_ack/imem_rdata       : memory response
//   instr/instr_valid/pc      : held instruction and its address to decode
//   instr_ready               : decoder accepts the held instruction
//   branch/zero/jump          : control-flow decision for the held instruction
//   imm16/jaddr               : branch offset and jump target fields
// Modports:
//   master : the fetch unit
//   slave  : memory + decoder side
// ----------------------------------------------------------------------------
interface fetch_unit_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] pc;

  logic        branch;
  logic        zero;
  logic        jump;
  logic [15:0] imm16;
  logic [25:0] jaddr;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata,
    output instr,
    output instr_valid,
    input  instr_ready,
    output pc,
    input  branch,
    input  zero,
    input  jump,
    input  imm16,
    input  jaddr
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata,
    input  instr,
    input  instr_valid,
    output instr_ready,
    input  pc,
    output branch,
    output zero,
    output jump,
    output imm16,
    output jaddr
  );

endinterface

// File: rtl/next_pc_calc.sv
// ----------------------------------------------------------------------------
// next_pc_calc
// Purely combinational next program counter selection.
//   pc      in  32 : address of the instruction being retired
//   branch  in   1 : conditional branch instruction
//   zero    in   1 : branch condition (ALU equality) is true
//   jump    in   1 : unconditional jump instruction
//   imm16   in  16 : signed branch offset in instructions
//   jaddr   in  26 : jump target in instructions within the current region
//   next_pc out 32 : jump target, taken-branch target, or pc + PC_STEP
// All arithmetic wraps modulo 2^32.
// ----------------------------------------------------------------------------
module next_pc_calc
  import cpu_pkg::*;
#(
  parameter logic [31:0] PC_STEP = PC_STEP_DEFAULT
) (
  input  logic [31:0] pc,
  input  logic        branch,
  input  logic        zero,
  input  logic        jump,
  input  logic [15:0] imm16,
  input  logic [25:0] jaddr,
  output logic [31:0] next_pc
);

  logic [31:0] pc_plus;
  logic [31:0] branch_target;
  logic [31:0] jump_target;

  always_comb begin
    pc_plus       = pc + PC_STEP;
    branch_target = pc_plus + sext_imm16_x4(imm16);
    // Jumps stay inside the 256 MB region of the sequential successor.
    jump_target   = {pc_plus[31:28], jaddr, 2'b00};

    next_pc = pc_plus;
    if (jump) begin
      next_pc = jump_target;
    end else if (branch && zero) begin
      next_pc = branch_target;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit
// Single-outstanding instruction fetch stage. After reset it idles for one
// cycle, then requests the word at pc, holds the returned word for the
// decoder, and on acceptance moves pc to the sequential, branch or jump
// successor before fetching again.
//   clk    in  1 : clock, rising edge
//   rst_n  in  1 : asynchronous active-low reset
//   bus    fetch_unit_if.master : memory bus, decoder hand-off and controls
// Parameters:
//   RESET_PC : pc value loaded by reset
//   PC_STEP  : byte increment for sequential instructions
// ----------------------------------------------------------------------------
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master bus
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  next_pc;

  // Control inputs only matter in the accepting HOLD cycle, where next_pc is
  // the sole consumer, so no gating is needed here.
  next_pc_calc #(
    .PC_STEP (PC_STEP)
  ) u_next_pc_calc (
    .pc      (pc_q),
    .branch  (bus.branch),
    .zero    (bus.zero),
    .jump    (bus.jump),
    .imm16   (bus.imm16),
    .jaddr   (bus.jaddr),
    .next_pc (next_pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  // imem_ack is only looked at in REQ, so acks arriving in IDLE or HOLD
  // (including a late ack from a fetch abandoned by reset) are dropped.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;

    case (state_q)
      IDLE: begin
        state_d = REQ;
      end
      REQ: begin
        if (bus.imem_ack) begin
          instr_d = bus.imem_rdata;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (bus.instr_ready) begin
          pc_d    = next_pc;
          state_d = REQ;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decode directly from registered state so they are glitch-free
  // and forced inactive as soon as reset asserts.
  assign bus.imem_req    = (state_q == REQ);
  assign bus.instr_valid = (state_q == HOLD);
  assign bus.imem_addr   = pc_q;
  assign bus.pc          = pc_q;
  assign bus.instr       = instr_q;

endmodule

// File: tb/tb_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_fetch_unit
// Directed bench for fetch_unit with a transaction-level reference model and
// literal expectations for the key control-flow cases.
// ----------------------------------------------------------------------------
module tb_fetch_unit;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  bit   cmp_en;

  fetch_unit_if bus ();

  fetch_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: what the fetch stage should present, tracked as
  // "waiting one cycle", "fetching" or "holding".
  localparam int PH_WAIT  = 0;
  localparam int PH_FETCH = 1;
  localparam int PH_HOLD  = 2;

  int          m_phase;
  logic [31:0] m_pc;
  logic [31:0] m_instr;

  function automatic logic [31:0] model_next(input logic [31:0] p,
                                             input logic br, input logic zr,
                                             input logic jp,
                                             input logic [15:0] im,
                                             input logic [25:0] ja);
    logic [31:0] seq;
    int          off;
    seq = p + 32'd4;
    if (jp) return (seq & 32'hF000_0000) | (32'(ja) << 2);
    if (br && zr) begin
      off = int'($signed(im));
      return seq + 32'(off * 4);
    end
    return seq;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= PH_WAIT;
      m_pc    <= 32'h0;
      m_instr <= 32'h0;
    end else begin
      case (m_phase)
        PH_WAIT: m_phase <= PH_FETCH;
        PH_FETCH: begin
          if (bus.imem_ack) begin
            m_instr <= bus.imem_rdata;
            m_phase <= PH_HOLD;
          end
        end
        default: begin
          if (bus.instr_ready) begin
            m_pc    <= model_next(m_pc, bus.branch, bus.zero, bus.jump,
                                  bus.imm16, bus.jaddr);
            m_phase <= PH_FETCH;
          end
        end
      endcase
    end
  end

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Every cycle the model and DUT outputs are compared on the falling edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      check_output("cmp_imem_req",    32'(bus.imem_req),    32'(m_phase == PH_FETCH));
      check_output("cmp_instr_valid", 32'(bus.instr_valid), 32'(m_phase == PH_HOLD));
      check_output("cmp_imem_addr",   bus.imem_addr,        m_pc);
      check_output("cmp_pc",          bus.pc,               m_pc);
      check_output("cmp_instr",       bus.instr,            m_instr);
    end
  end

  task automatic wait_req();
    int n;
    n = 0;
    while (bus.imem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_output("wait_req", 32'(bus.imem_req), 32'd1);
  endtask

  task automatic apply_stimulus_fetch(input logic [31:0] data, input int waits,
                                      input logic [31:0] exp_addr);
    wait_req();
    for (int i = 0; i < waits; i++) begin
      bus.imem_ack = 1'b0;
      @(negedge clk);
      check_output("wait_req_held",   32'(bus.imem_req),    32'd1);
      check_output("wait_addr",       bus.imem_addr,        exp_addr);
      check_output("wait_not_valid",  32'(bus.instr_valid), 32'd0);
    end
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = data;
    @(negedge clk);
    check_output("fetch_valid", 32'(bus.instr_valid), 32'd1);
    check_output("fetch_instr", bus.instr,            data);
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = $urandom;
  endtask

  task automatic apply_stimulus_accept(input logic br, input logic zr,
                                       input logic jp, input logic [15:0] im,
                                       input logic [25:0] ja, input int stalls,
                                       input logic [31:0] exp_pc);
    check_output("hold_valid", 32'(bus.instr_valid), 32'd1);
    for (int i = 0; i < stalls; i++) begin
      bus.instr_ready = 1'b0;
      bus.branch      = ~bus.branch;
      bus.zero        = 1'b1;
      bus.jump        = 1'($urandom);
      bus.imm16       = 16'($urandom);
      bus.jaddr       = 26'($urandom);
      bus.imem_ack    = 1'b1;
      @(negedge clk);
    end
    bus.imem_ack    = 1'b0;
    bus.instr_ready = 1'b1;
    bus.branch      = br;
    bus.zero        = zr;
    bus.jump        = jp;
    bus.imm16       = im;
    bus.jaddr       = ja;
    @(negedge clk);
    check_output("accept_pc", bus.pc, exp_pc);
    bus.instr_ready = 1'b0;
    bus.branch      = 1'($urandom);
    bus.zero        = 1'($urandom);
    bus.jump        = 1'($urandom);
    bus.imm16       = 16'($urandom);
    bus.jaddr       = 26'($urandom);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    total           = 0;
    bad             = 0;
    cmp_en          = 1'b0;
    bus.imem_ack    = 1'b0;
    bus.imem_rdata  = 32'h0;
    bus.instr_ready = 1'b0;
    bus.branch      = 1'b0;
    bus.zero        = 1'b0;
    bus.jump        = 1'b0;
    bus.imm16       = 16'h0;
    bus.jaddr       = 26'h0;
    rst_n           = 1'b1;
    #1 rst_n = 1'b0;
    cmp_en = 1'b1;

    // Pin the reference model against hand-computed targets.
    check_output("model_branch_back", model_next(32'h40, 1'b1, 1'b1, 1'b0, 16'hFFFE, 26'h0), 32'h3C);
    check_output("model_jump_wins",   model_next(32'h1000_0010, 1'b1, 1'b1, 1'b1, 16'h0, 26'h100), 32'h1000_0400);
    check_output("model_wrap",        model_next(32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0), 32'h0);

    @(negedge clk);
    check_output("reset_pc",    bus.pc,                32'h0);
    check_output("reset_instr", bus.instr,             32'h0);
    check_output("reset_valid", 32'(bus.instr_valid),  32'd0);
    check_output("reset_req",   32'(bus.imem_req),     32'd0);

    // First fetch: idle one cycle, immediate ack, accept right away.
    @(negedge clk);
    rst_n = 1'b1;
    #1 check_output("idle_no_req", 32'(bus.imem_req), 32'd0);
    @(negedge clk);
    check_output("first_req", 32'(bus.imem_req), 32'd1);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'h2008_0005;
    @(negedge clk);
    check_output("first_valid", 32'(bus.instr_valid), 32'd1);
    check_output("first_instr", bus.instr,            32'h2008_0005);
    check_output("first_pc",    bus.pc,               32'h0);
    bus.imem_ack    = 1'b0;
    bus.instr_ready = 1'b1;
    @(negedge clk);
    check_output("first_next_pc", bus.pc, 32'h4);
    bus.instr_ready = 1'b0;

    // Memory wait states, then jump to 0x40.
    apply_stimulus_fetch(32'h1111_0001, 3, 32'h4);
    apply_stimulus_accept(1'b0, 1'b0, 1'b1, 16'h0, 26'h10, 0, 32'h40);

    // Backward taken branch.
    apply_stimulus_fetch(32'h1111_0002, 0, 32'h40);
    apply_stimulus_accept(1'b1, 1'b1, 1'b0, 16'hFFFE, 26'h0, 0, 32'h3C);

    // Decoder stall with toggling controls and stray acks, then untaken branch.
    apply_stimulus_fetch(32'h1111_0003, 1, 32'h3C);
    apply_stimulus_accept(1'b1, 1'b0, 1'b0, 16'h0100, 26'h0, 5, 32'h40);

    // Wrap-around: go to 0, branch back to 0xFFFF_FFFC, step to 0.
    apply_stimulus_fetch(32'h1111_0004, 0, 32'h40);
    apply_stimulus_accept(1'b0, 1'b0, 1'b1, 16'h0, 26'h0, 0, 32'h0);
    apply_stimulus_fetch(32'h1111_0005, 0, 32'h0);
    apply_stimulus_accept(1'b1, 1'b1, 1'b0, 16'hFFFE, 26'h0, 0, 32'hFFFF_FFFC);
    apply_stimulus_fetch(32'h1111_0006, 2, 32'hFFFF_FFFC);
    apply_stimulus_accept(1'b0, 1'b0, 1'b0, 16'h0, 26'h0, 0, 32'h0);

    // Climb to 0x1000_0010 with maximal forward branches (+0x20000 each).
    apply_stimulus_fetch(32'h1111_0007, 0, 32'h0);
    apply_stimulus_accept(1'b0, 1'b0, 1'b1, 16'h0, 26'h4, 0, 32'h10);
    for (int i = 0; i < 2048; i++) begin
      apply_stimulus_fetch($urandom, 0, 32'h10 + 32'(i) * 32'h20000);
      apply_stimulus_accept(1'b1, 1'b1, 1'b0, 16'h7FFF, 26'h0, 0,
                            32'h10 + 32'(i + 1) * 32'h20000);
    end

    // Jump has priority over a taken branch.
    apply_stimulus_fetch(32'h1111_0008, 0, 32'h1000_0010);
    apply_stimulus_accept(1'b1, 1'b1, 1'b1, 16'h1234, 26'h100, 0, 32'h1000_0400);

    // Reset in the middle of a fetch, followed by a late ack.
    check_output("pre_reset_req", 32'(bus.imem_req), 32'd1);
    bus.imem_ack = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_output("midreset_pc",    bus.pc,               32'h0);
    check_output("midreset_valid", 32'(bus.instr_valid), 32'd0);
    check_output("midreset_req",   32'(bus.imem_req),    32'd0);
    check_output("midreset_instr", bus.instr,            32'h0);
    @(negedge clk);
    rst_n          = 1'b1;
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check_output("late_ack_instr", bus.instr,            32'h0);
    check_output("late_ack_valid", 32'(bus.instr_valid), 32'd0);
    check_output("late_ack_pc",    bus.pc,               32'h0);
    check_output("late_ack_req",   32'(bus.imem_req),    32'd1);
    bus.imem_ack = 1'b0;

    apply_stimulus_fetch(32'h2008_0005, 0, 32'h0);
    apply_stimulus_accept(1'b0, 1'b0, 1'b0, 16'h0, 26'h0, 0, 32'h4);

    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
